writeback_stage: RTL and testbench

//  Final pipeline stage; consumes the memory-stage buffered outputs (wb_sel, data, ALU, LDM, in-port, rd addr).

---
 rtl/writeback_stage_if.sv | 51 +++++
 rtl/writeback_stage.sv | 132 +++++++++++++
 tb/tb_writeback_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// writeback_stage_if : MEM-buffer inputs, RF write port, OUT port, forwarding
// Revision: 1.0
// ----------------------------------------------------------------------------
interface writeback_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 32
);
  logic              instr_valid;
  logic              flush;
  logic [1:0]        wb_sel;
  logic [DATA_W-1:0] alu_value;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] ldm_value;
  logic [DATA_W-1:0] input_port;
  logic [DATA_W-1:0] out_data;
  logic              reg_write;
  logic [ADDR_W-1:0] reg_write_addr;
  logic              outport_enable;
  logic [ADDR_W-1:0] src1_addr;
  logic [ADDR_W-1:0] src2_addr;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] output_port;
  logic              out_strobe;
  logic              fwd1_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd2_data;
  logic [CNT_W-1:0]  retired_count;

  modport master (
    output instr_valid, flush, wb_sel, alu_value, mem_data, ldm_value,
           input_port, out_data, reg_write, reg_write_addr, outport_enable,
           src1_addr, src2_addr,
    input  rf_we, rf_waddr, rf_wdata, output_port, out_strobe,
           fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, retired_count
  );

  modport slave (
    input  instr_valid, flush, wb_sel, alu_value, mem_data, ldm_value,
           input_port, out_data, reg_write, reg_write_addr, outport_enable,
           src1_addr, src2_addr,
    output rf_we, rf_waddr, rf_wdata, output_port, out_strobe,
           fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, retired_count
  );
endinterface
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// writeback_stage : write-back mux, OUT port register, retired-write history
// Revision: 1.0
// ----------------------------------------------------------------------------
module writeback_stage #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int HIST_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input wire clk,
  input wire reset,
  writeback_stage_if.slave wb
);
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              w_live;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;

  logic [DATA_W-1:0] r_output_port;
  logic              r_out_strobe;
  logic [CNT_W-1:0]  r_count;

  logic              r_hist_v    [HIST_DEPTH];
  logic [ADDR_W-1:0] r_hist_addr [HIST_DEPTH];
  logic [DATA_W-1:0] r_hist_data [HIST_DEPTH];

  logic              w_fwd1_hit;
  logic [DATA_W-1:0] w_fwd1_data;
  logic              w_fwd2_hit;
  logic [DATA_W-1:0] w_fwd2_data;

  assign w_live = wb.instr_valid & ~wb.flush;
  // Gating with reset keeps the register file from capturing while reset is held.
  assign w_we   = w_live & wb.reg_write & ~reset;

  always_comb begin
    w_wdata = wb.alu_value;
    case (wb.wb_sel)
      2'b00:   w_wdata = wb.alu_value;
      2'b01:   w_wdata = wb.mem_data;
      2'b10:   w_wdata = wb.ldm_value;
      default: w_wdata = wb.input_port;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_output_port <= '0;
      r_out_strobe  <= 1'b0;
      r_count       <= '0;
    end else begin
      r_out_strobe <= w_live & wb.outport_enable;
      if (w_live && wb.outport_enable) begin
        r_output_port <= wb.out_data;
      end
      if (w_live) begin
        r_count <= r_count + C_CNT_ONE;
      end
    end
  end

  // Entry pushed every cycle, so entry index equals cycles since retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist_v[0]    <= 1'b0;
      r_hist_addr[0] <= '0;
      r_hist_data[0] <= '0;
    end else begin
      r_hist_v[0]    <= w_we;
      r_hist_addr[0] <= wb.reg_write_addr;
      r_hist_data[0] <= w_wdata;
    end
  end

  generate
    for (genvar gi = 1; gi < HIST_DEPTH; gi++) begin : g_hist_shift
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_hist_v[gi]    <= 1'b0;
          r_hist_addr[gi] <= '0;
          r_hist_data[gi] <= '0;
        end else begin
          r_hist_v[gi]    <= r_hist_v[gi-1];
          r_hist_addr[gi] <= r_hist_addr[gi-1];
          r_hist_data[gi] <= r_hist_data[gi-1];
        end
      end
    end
  endgenerate

  // Scan oldest to newest so the youngest match overrides; current write last.
  always_comb begin
    w_fwd1_hit  = 1'b0;
    w_fwd1_data = '0;
    w_fwd2_hit  = 1'b0;
    w_fwd2_data = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (r_hist_v[i] && (r_hist_addr[i] == wb.src1_addr)) begin
        w_fwd1_hit  = 1'b1;
        w_fwd1_data = r_hist_data[i];
      end
      if (r_hist_v[i] && (r_hist_addr[i] == wb.src2_addr)) begin
        w_fwd2_hit  = 1'b1;
        w_fwd2_data = r_hist_data[i];
      end
    end
    if (w_we && (wb.reg_write_addr == wb.src1_addr)) begin
      w_fwd1_hit  = 1'b1;
      w_fwd1_data = w_wdata;
    end
    if (w_we && (wb.reg_write_addr == wb.src2_addr)) begin
      w_fwd2_hit  = 1'b1;
      w_fwd2_data = w_wdata;
    end
  end

  assign wb.rf_we         = w_we;
  assign wb.rf_waddr      = wb.reg_write_addr;
  assign wb.rf_wdata      = w_wdata;
  assign wb.output_port   = r_output_port;
  assign wb.out_strobe    = r_out_strobe;
  assign wb.fwd1_hit      = w_fwd1_hit;
  assign wb.fwd1_data     = w_fwd1_data;
  assign wb.fwd2_hit      = w_fwd2_hit;
  assign wb.fwd2_data     = w_fwd2_data;
  assign wb.retired_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_writeback_stage : directed vector bench for writeback_stage (CNT_W=4)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_writeback_stage;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [CNT_W-1:0] exp_cnt;

  writeback_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  writeback_stage #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .HIST_DEPTH(2), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .wb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        iv;
    logic        fl;
    logic        rw;
    logic [2:0]  addr;
    logic [15:0] exp_wdata;
    logic        exp_we;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.instr_valid    = 1'b0;
    bus.flush          = 1'b0;
    bus.reg_write      = 1'b0;
    bus.outport_enable = 1'b0;
  endtask

  // Advance one clock; the count model follows the bench's own driven inputs.
  task automatic tick();
    logic live;
    live = bus.instr_valid & ~bus.flush;
    @(posedge clk);
    #1;
    if (!reset && live) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic drive_write(input logic [2:0] addr, input logic [15:0] val);
    bus.instr_valid    = 1'b1;
    bus.flush          = 1'b0;
    bus.reg_write      = 1'b1;
    bus.outport_enable = 1'b0;
    bus.wb_sel         = 2'b00;
    bus.reg_write_addr = addr;
    bus.alu_value      = val;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = '0;

    vecs[0] = '{2'd0, 1'b1, 1'b0, 1'b1, 3'd5, 16'h1111, 1'b1};
    vecs[1] = '{2'd1, 1'b1, 1'b0, 1'b1, 3'd5, 16'h2222, 1'b1};
    vecs[2] = '{2'd2, 1'b1, 1'b0, 1'b1, 3'd5, 16'h3333, 1'b1};
    vecs[3] = '{2'd3, 1'b1, 1'b0, 1'b1, 3'd5, 16'h4444, 1'b1};
    vecs[4] = '{2'd0, 1'b1, 1'b0, 1'b0, 3'd5, 16'h1111, 1'b0};
    vecs[5] = '{2'd1, 1'b1, 1'b1, 1'b1, 3'd5, 16'h2222, 1'b0};
    vecs[6] = '{2'd2, 1'b0, 1'b0, 1'b1, 3'd6, 16'h3333, 1'b0};

    // Reset state, with a live write driven to prove rf_we is gated.
    reset              = 1'b1;
    bus.instr_valid    = 1'b1;
    bus.flush          = 1'b0;
    bus.reg_write      = 1'b1;
    bus.outport_enable = 1'b0;
    bus.wb_sel         = 2'b00;
    bus.alu_value      = 16'h1111;
    bus.mem_data       = 16'h2222;
    bus.ldm_value      = 16'h3333;
    bus.input_port     = 16'h4444;
    bus.out_data       = 16'h0000;
    bus.reg_write_addr = 3'd0;
    bus.src1_addr      = 3'd0;
    bus.src2_addr      = 3'd0;
    #2;
    check("reset_rf_we", {31'd0, bus.rf_we}, 32'd0);
    check("reset_port", {16'd0, bus.output_port}, 32'd0);
    check("reset_strobe", {31'd0, bus.out_strobe}, 32'd0);
    check("reset_count", {28'd0, bus.retired_count}, 32'd0);
    check("reset_fwd1_hit", {31'd0, bus.fwd1_hit}, 32'd0);
    idle();
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Write-back mux table.
    for (int i = 0; i < 7; i++) begin
      bus.wb_sel         = vecs[i].sel;
      bus.instr_valid    = vecs[i].iv;
      bus.flush          = vecs[i].fl;
      bus.reg_write      = vecs[i].rw;
      bus.reg_write_addr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_wdata", i), {16'd0, bus.rf_wdata}, {16'd0, vecs[i].exp_wdata});
      check($sformatf("vec%0d_we", i), {31'd0, bus.rf_we}, {31'd0, vecs[i].exp_we});
      check($sformatf("vec%0d_waddr", i), {29'd0, bus.rf_waddr}, {29'd0, vecs[i].addr});
      tick();
    end
    check("count_after_table", {28'd0, bus.retired_count}, 32'd5);

    // OUT port: live update, one-cycle strobe, hold, then flushed OUT ignored.
    idle();
    bus.instr_valid    = 1'b1;
    bus.outport_enable = 1'b1;
    bus.out_data       = 16'hABCD;
    #1;
    check("out_strobe_pre", {31'd0, bus.out_strobe}, 32'd0);
    tick();
    check("out_port", {16'd0, bus.output_port}, 32'h0000ABCD);
    check("out_strobe", {31'd0, bus.out_strobe}, 32'd1);
    idle();
    tick();
    check("out_hold", {16'd0, bus.output_port}, 32'h0000ABCD);
    check("out_strobe_drop", {31'd0, bus.out_strobe}, 32'd0);
    bus.instr_valid    = 1'b1;
    bus.flush          = 1'b1;
    bus.reg_write      = 1'b1;
    bus.outport_enable = 1'b1;
    bus.out_data       = 16'h5555;
    tick();
    check("flush_out_port", {16'd0, bus.output_port}, 32'h0000ABCD);
    check("flush_out_strobe", {31'd0, bus.out_strobe}, 32'd0);
    check("flush_count", {28'd0, bus.retired_count}, {28'd0, exp_cnt});

    // History ageing: R3 written twice, then aged out after HIST_DEPTH cycles.
    idle();
    tick();
    tick();
    drive_write(3'd3, 16'h0011);
    tick();
    drive_write(3'd3, 16'h0022);
    tick();
    idle();
    bus.src1_addr = 3'd3;
    #1;
    check("hist_t2_hit", {31'd0, bus.fwd1_hit}, 32'd1);
    check("hist_t2_data", {16'd0, bus.fwd1_data}, 32'h00000022);
    tick();
    check("hist_t3_hit", {31'd0, bus.fwd1_hit}, 32'd1);
    check("hist_t3_data", {16'd0, bus.fwd1_data}, 32'h00000022);
    tick();
    check("hist_t4_hit", {31'd0, bus.fwd1_hit}, 32'd0);
    check("hist_t4_data", {16'd0, bus.fwd1_data}, 32'd0);

    // Current-cycle write beats history; a flushed write does not.
    drive_write(3'd2, 16'h0055);
    tick();
    drive_write(3'd2, 16'h0077);
    bus.src2_addr = 3'd2;
    #1;
    check("prio_cur_hit", {31'd0, bus.fwd2_hit}, 32'd1);
    check("prio_cur_data", {16'd0, bus.fwd2_data}, 32'h00000077);
    bus.flush = 1'b1;
    #1;
    check("prio_flush_data", {16'd0, bus.fwd2_data}, 32'h00000055);
    check("prio_flush_we", {31'd0, bus.rf_we}, 32'd0);
    tick();

    // Register write and OUT together.
    drive_write(3'd1, 16'h2468);
    bus.outport_enable = 1'b1;
    bus.out_data       = 16'h1357;
    #1;
    check("both_we", {31'd0, bus.rf_we}, 32'd1);
    tick();
    check("both_port", {16'd0, bus.output_port}, 32'h00001357);
    check("both_strobe", {31'd0, bus.out_strobe}, 32'd1);

    // Counter wrap (CNT_W=4) and bubbles not counted.
    idle();
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 16 && exp_cnt != 4'hF; i++) tick();
    check("count_max", {28'd0, bus.retired_count}, 32'd15);
    tick();
    check("count_wrap", {28'd0, bus.retired_count}, 32'd0);
    idle();
    tick();
    bus.instr_valid = 1'b1;
    bus.flush       = 1'b1;
    tick();
    check("count_bubble_flush", {28'd0, bus.retired_count}, 32'd0);

    // Asynchronous reset mid-cycle after OUT and two writes.
    idle();
    bus.instr_valid    = 1'b1;
    bus.outport_enable = 1'b1;
    bus.out_data       = 16'h1234;
    tick();
    drive_write(3'd4, 16'h0444);
    tick();
    drive_write(3'd5, 16'h0555);
    bus.src1_addr = 3'd4;
    bus.src2_addr = 3'd5;
    #1;
    check("pre_rst_hit1", {31'd0, bus.fwd1_hit}, 32'd1);
    check("pre_rst_port", {16'd0, bus.output_port}, 32'h00001234);
    #1;
    reset = 1'b1;
    #1;
    check("rst_port", {16'd0, bus.output_port}, 32'd0);
    check("rst_hit1", {31'd0, bus.fwd1_hit}, 32'd0);
    check("rst_hit2", {31'd0, bus.fwd2_hit}, 32'd0);
    check("rst_count", {28'd0, bus.retired_count}, 32'd0);
    check("rst_we", {31'd0, bus.rf_we}, 32'd0);
    idle();
    tick();
    reset   = 1'b0;
    exp_cnt = '0;
    tick();
    check("post_rst_port", {16'd0, bus.output_port}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
